// File: rtl/alu8_top.sv
// 8-bit ALU: combinational result path plus a registered carry/zero status stage.
// Flags reflect the operation presented during the previous clock cycle.
module alu8_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] sum_ext;
    logic           carry_c;

    always_comb begin
        out     = '0;
        carry_c = 1'b0;
        sum_ext = '0;
        case (sel)
            3'b000: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                out     = sum_ext[WIDTH-1:0];
                carry_c = sum_ext[WIDTH];
            end
            3'b001: begin
                out     = a - b;
                carry_c = (a < b);
            end
            3'b010: out = a & b;
            3'b011: out = a | b;
            3'b100: out = a ^ b;
            3'b101: out = ~a;
            3'b110: begin
                out     = {a[WIDTH-2:0], 1'b0};
                carry_c = a[WIDTH-1];
            end
            3'b111: begin
                out     = {1'b0, a[WIDTH-1:1]};
                carry_c = a[0];
            end
            default: begin
                out     = '0;
                carry_c = 1'b0;
            end
        endcase
    end

    // Status stage: rst is active-low and clears the flags without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            carry <= carry_c;
            zero  <= (out == '0);
        end
    end

endmodule

// File: tb/tb_alu8_top.sv
// Self-checking bench for alu8_top: directed corner cases, randomized vectors
// against an arithmetic reference model, and an asynchronous mid-run reset.
module tb_alu8_top;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] out;
    logic       carry;
    logic       zero;

    int n_checks;
    int n_fails;

    alu8_top #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .sel  (sel),
        .out  (out),
        .carry(carry),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the opcode rules using plain integer arithmetic.
    function automatic int model_out(input int ai, input int bi, input int op);
        case (op)
            0: return (ai + bi) % 256;
            1: return (ai - bi + 256) % 256;
            2: return ai & bi;
            3: return ai | bi;
            4: return ai ^ bi;
            5: return 255 - ai;
            6: return (ai * 2) % 256;
            default: return ai / 2;
        endcase
    endfunction

    function automatic int model_carry(input int ai, input int bi, input int op);
        case (op)
            0: return (ai + bi > 255) ? 1 : 0;
            1: return (ai < bi) ? 1 : 0;
            6: return ai / 128;
            7: return ai % 2;
            default: return 0;
        endcase
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Called 1 ns after a rising edge: drive, check out mid-cycle, then flags after the edge.
    task automatic run_vec(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [2:0] sv);
        int eo;
        int ec;
        a   = av;
        b   = bv;
        sel = sv;
        eo  = model_out(int'(av), int'(bv), int'(sv));
        ec  = model_carry(int'(av), int'(bv), int'(sv));
        #4;
        check8({tag, ".out"}, out, 8'(eo));
        @(posedge clk);
        #1;
        check1({tag, ".carry"}, carry, ec[0]);
        check1({tag, ".zero"}, zero, (eo == 0));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b0;
        a   = 8'h00;
        b   = 8'h00;
        sel = 3'b000;

        #3;
        check1("reset.carry", carry, 1'b0);
        check1("reset.zero", zero, 1'b0);
        @(posedge clk);
        #1;
        check1("reset_held.carry", carry, 1'b0);
        check1("reset_held.zero", zero, 1'b0);
        rst = 1'b1;

        // Directed cases with hand-computed expected values.
        a = 8'hFF; b = 8'h01; sel = 3'b000;
        #4;
        check8("add_wrap.out", out, 8'h00);
        @(posedge clk); #1;
        check1("add_wrap.carry", carry, 1'b1);
        check1("add_wrap.zero", zero, 1'b1);

        a = 8'h05; b = 8'h07; sel = 3'b001;
        #4;
        check8("sub_borrow.out", out, 8'hFE);
        @(posedge clk); #1;
        check1("sub_borrow.carry", carry, 1'b1);
        check1("sub_borrow.zero", zero, 1'b0);

        a = 8'h07; b = 8'h05; sel = 3'b001;
        #4;
        check8("sub_nob.out", out, 8'h02);
        @(posedge clk); #1;
        check1("sub_nob.carry", carry, 1'b0);

        a = 8'hA5; b = 8'h3C; sel = 3'b010;
        #1; check8("and.out", out, 8'h24);
        sel = 3'b011;
        #1; check8("or.out", out, 8'hBD);
        sel = 3'b100;
        #1; check8("xor.out", out, 8'h99);
        sel = 3'b101;
        #1; check8("not.out", out, 8'h5A);
        @(posedge clk); #1;
        check1("not.carry", carry, 1'b0);

        a = 8'h81; b = 8'h00; sel = 3'b110;
        #4;
        check8("shl.out", out, 8'h02);
        @(posedge clk); #1;
        check1("shl.carry", carry, 1'b1);

        sel = 3'b111;
        #4;
        check8("shr.out", out, 8'h40);
        @(posedge clk); #1;
        check1("shr.carry", carry, 1'b1);

        // Back-to-back opcodes through the model, including all-zero and all-one operands.
        for (int op = 0; op < 8; op++) begin
            run_vec("edge00", 8'h00, 8'h00, 3'(op));
            run_vec("edgeFF", 8'hFF, 8'hFF, 3'(op));
        end

        // Randomized vectors, one per cycle.
        for (int i = 0; i < 3000; i++) begin
            run_vec("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    3'($urandom_range(0, 7)));
        end

        // Mid-run reset with carry latched.
        a = 8'hFF; b = 8'h02; sel = 3'b000;
        @(posedge clk); #1;
        check1("pre_rst.carry", carry, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check1("async_rst.carry", carry, 1'b0);
        check1("async_rst.zero", zero, 1'b0);
        check8("async_rst.out", out, 8'h01);
        a = 8'h10; b = 8'h20;
        #1;
        check8("rst_out_follows", out, 8'h30);
        @(posedge clk); #1;
        check1("rst_hold.carry", carry, 1'b0);
        check1("rst_hold.zero", zero, 1'b0);
        a = 8'h80; b = 8'h80;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check1("rst_release.carry", carry, 1'b1);
        check1("rst_release.zero", zero, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
